// File: rtl/vga_axil_pkg.sv
// Shared widths, bus types and FSM state encodings for the VGA AXI4-Lite slave.
package vga_axil_pkg;
  localparam int AXIL_ADDR_W   = 32;
  localparam int AXIL_DATA_W   = 32;
  localparam int NATIVE_ADDR_W = AXIL_ADDR_W - 2;

  typedef logic [AXIL_ADDR_W-1:0]   axil_addr_t;
  typedef logic [AXIL_DATA_W-1:0]   axil_data_t;
  typedef logic [NATIVE_ADDR_W-1:0] native_addr_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axil_resp_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_EXEC = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_EXEC = 2'd1,
    R_CAPT = 2'd2,
    R_RESP = 2'd3
  } rd_state_e;
endpackage

// File: rtl/axil_slave_rd_fsm.sv
// AXI4-Lite read path: AR handshake -> native read strobe -> capture data_i -> R response.
// Misaligned reads answer SLVERR with zero data when VGA_AXIL_SLVERR_EN is defined.
module axil_slave_rd_fsm
  import vga_axil_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     arst_i,
  input  logic [AXIL_ADDR_W-1:0]   s_axil_araddr,
  input  logic                     s_axil_arvalid,
  output logic                     s_axil_arready,
  output logic [AXIL_DATA_W-1:0]   s_axil_rdata,
  output logic [1:0]               s_axil_rresp,
  output logic                     s_axil_rvalid,
  input  logic                     s_axil_rready,
  input  logic [AXIL_DATA_W-1:0]   data_i,
  output logic [NATIVE_ADDR_W-1:0] addr_read_o,
  output logic                     read_en_o
);

  rd_state_e    state_q, state_d;
  logic         arready_q, arready_d;
  logic         ar_err_q, ar_err_d;
  logic         ar_err;
  native_addr_t addr_q, addr_d;
  axil_data_t   rdata_q, rdata_d;
  axil_resp_e   rresp_q, rresp_d;
  logic         unused_addr_lsb;

`ifdef VGA_AXIL_SLVERR_EN
  assign ar_err = (s_axil_araddr[1:0] != 2'b00);
`else
  assign ar_err = 1'b0;
`endif
  assign unused_addr_lsb = ^s_axil_araddr[1:0];

  always_comb begin
    state_d  = state_q;
    ar_err_d = ar_err_q;
    addr_d   = addr_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    unique case (state_q)
      R_IDLE: begin
        if (s_axil_arvalid && arready_q) begin
          addr_d   = s_axil_araddr[AXIL_ADDR_W-1:2];
          ar_err_d = ar_err;
          state_d  = R_EXEC;
        end
      end
      R_EXEC: state_d = R_CAPT;
      R_CAPT: begin
        // data_i answers the strobe issued in R_EXEC one cycle later
        if (ar_err_q) begin
          rdata_d = '0;
          rresp_d = SLVERR;
        end else begin
          rdata_d = data_i;
          rresp_d = OKAY;
        end
        state_d = R_RESP;
      end
      R_RESP: begin
        if (s_axil_rready) state_d = R_IDLE;
      end
      default: state_d = R_IDLE;
    endcase
    arready_d = (state_d == R_IDLE);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= R_IDLE;
      arready_q <= 1'b0;
      ar_err_q  <= 1'b0;
      addr_q    <= '0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      ar_err_q  <= ar_err_d;
      addr_q    <= addr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign s_axil_arready = arready_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign s_axil_rvalid  = (state_q == R_RESP);
  assign addr_read_o    = addr_q;
  assign read_en_o      = (state_q == R_EXEC) && !ar_err_q;

endmodule

// File: rtl/axil_slave_fsm.sv
// AXI4-Lite slave for the VGA register bank: write FSM here, read FSM in axil_slave_rd_fsm.
// Define VGA_AXIL_SLVERR_EN to reject misaligned accesses with SLVERR.
module axil_slave_fsm
  import vga_axil_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     arst_i,
  input  logic [AXIL_ADDR_W-1:0]   s_axil_awaddr,
  input  logic                     s_axil_awvalid,
  output logic                     s_axil_awready,
  input  logic [AXIL_DATA_W-1:0]   s_axil_wdata,
  input  logic [3:0]               s_axil_wstrb,
  input  logic                     s_axil_wvalid,
  output logic                     s_axil_wready,
  output logic [1:0]               s_axil_bresp,
  output logic                     s_axil_bvalid,
  input  logic                     s_axil_bready,
  input  logic [AXIL_ADDR_W-1:0]   s_axil_araddr,
  input  logic                     s_axil_arvalid,
  output logic                     s_axil_arready,
  output logic [AXIL_DATA_W-1:0]   s_axil_rdata,
  output logic [1:0]               s_axil_rresp,
  output logic                     s_axil_rvalid,
  input  logic                     s_axil_rready,
  input  logic [AXIL_DATA_W-1:0]   data_i,
  output logic [NATIVE_ADDR_W-1:0] addr_write_o,
  output logic [AXIL_DATA_W-1:0]   data_o,
  output logic                     write_en_o,
  output logic [NATIVE_ADDR_W-1:0] addr_read_o,
  output logic                     read_en_o
);

  wr_state_e    w_state_q, w_state_d;
  logic         awready_q, awready_d;
  logic         wready_q, wready_d;
  logic         aw_held_q, aw_held_d;
  logic         w_held_q, w_held_d;
  logic         aw_err_q, aw_err_d;
  logic         aw_err;
  native_addr_t addr_write_q, addr_write_d;
  axil_data_t   data_q, data_d;
  axil_resp_e   bresp_q, bresp_d;
  logic         unused_wr_bits;

`ifdef VGA_AXIL_SLVERR_EN
  assign aw_err = (s_axil_awaddr[1:0] != 2'b00);
`else
  assign aw_err = 1'b0;
`endif
  assign unused_wr_bits = ^{s_axil_wstrb, s_axil_awaddr[1:0]};

  // AW and W are collected independently; each ready stays low once its beat is held
  always_comb begin
    w_state_d    = w_state_q;
    aw_held_d    = aw_held_q;
    w_held_d     = w_held_q;
    aw_err_d     = aw_err_q;
    addr_write_d = addr_write_q;
    data_d       = data_q;
    bresp_d      = bresp_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (s_axil_awvalid && awready_q) begin
          aw_held_d    = 1'b1;
          addr_write_d = s_axil_awaddr[AXIL_ADDR_W-1:2];
          aw_err_d     = aw_err;
        end
        if (s_axil_wvalid && wready_q) begin
          w_held_d = 1'b1;
          data_d   = s_axil_wdata;
        end
        if (aw_held_d && w_held_d) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          w_state_d = W_EXEC;
        end
      end
      W_EXEC: begin
        if (aw_err_q) bresp_d = SLVERR;
        else          bresp_d = OKAY;
        w_state_d = W_RESP;
      end
      W_RESP: begin
        if (s_axil_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE) && !aw_held_d;
    wready_d  = (w_state_d == W_IDLE) && !w_held_d;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      w_state_q    <= W_IDLE;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      aw_held_q    <= 1'b0;
      w_held_q     <= 1'b0;
      aw_err_q     <= 1'b0;
      addr_write_q <= '0;
      data_q       <= '0;
      bresp_q      <= OKAY;
    end else begin
      w_state_q    <= w_state_d;
      awready_q    <= awready_d;
      wready_q     <= wready_d;
      aw_held_q    <= aw_held_d;
      w_held_q     <= w_held_d;
      aw_err_q     <= aw_err_d;
      addr_write_q <= addr_write_d;
      data_q       <= data_d;
      bresp_q      <= bresp_d;
    end
  end

  assign s_axil_awready = awready_q;
  assign s_axil_wready  = wready_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_bvalid  = (w_state_q == W_RESP);
  assign addr_write_o   = addr_write_q;
  assign data_o         = data_q;
  assign write_en_o     = (w_state_q == W_EXEC) && !aw_err_q;

  axil_slave_rd_fsm u_rd_fsm (
    .clk_i          (clk_i),
    .arst_i         (arst_i),
    .s_axil_araddr  (s_axil_araddr),
    .s_axil_arvalid (s_axil_arvalid),
    .s_axil_arready (s_axil_arready),
    .s_axil_rdata   (s_axil_rdata),
    .s_axil_rresp   (s_axil_rresp),
    .s_axil_rvalid  (s_axil_rvalid),
    .s_axil_rready  (s_axil_rready),
    .data_i         (data_i),
    .addr_read_o    (addr_read_o),
    .read_en_o      (read_en_o)
  );

endmodule

// File: tb/tb_axil_slave_fsm.sv
// Directed scoreboard bench for axil_slave_fsm with a small native register-bank model.
// Expected native strobes and AXI responses are queued as stimulus is driven.
module tb_axil_slave_fsm;

  logic        clk = 1'b0;
  logic        arst;
  logic [31:0] s_axil_awaddr, s_axil_wdata, s_axil_araddr;
  logic [3:0]  s_axil_wstrb;
  logic        s_axil_awvalid, s_axil_wvalid, s_axil_bready, s_axil_arvalid, s_axil_rready;
  logic        s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready, s_axil_rvalid;
  logic [1:0]  s_axil_bresp, s_axil_rresp;
  logic [31:0] s_axil_rdata, data_i, data_o;
  logic [29:0] addr_write_o, addr_read_o;
  logic        write_en_o, read_en_o;

  typedef struct { logic [29:0] addr; logic [31:0] data; } wr_exp_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; } rd_exp_t;

  wr_exp_t     wr_q[$];
  logic [29:0] rd_addr_q[$];
  logic [1:0]  b_q[$];
  rd_exp_t     r_q[$];

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int aw_cyc, w_cyc, ar_cyc;
  int wr_en_cyc = -1, rd_en_cyc = -1, b_rise_cyc = -1, r_rise_cyc = -1;
  logic bvalid_prev = 1'b0, rvalid_prev = 1'b0;
  logic [31:0] mem [0:255];
  logic [31:0] rnd_addr [10];
  logic [31:0] rnd_data [10];
  wr_exp_t     mon_w;
  rd_exp_t     mon_r;
  logic [29:0] mon_a;
  logic [1:0]  mon_b;

  axil_slave_fsm dut (
    .clk_i          (clk),
    .arst_i         (arst),
    .s_axil_awaddr  (s_axil_awaddr),
    .s_axil_awvalid (s_axil_awvalid),
    .s_axil_awready (s_axil_awready),
    .s_axil_wdata   (s_axil_wdata),
    .s_axil_wstrb   (s_axil_wstrb),
    .s_axil_wvalid  (s_axil_wvalid),
    .s_axil_wready  (s_axil_wready),
    .s_axil_bresp   (s_axil_bresp),
    .s_axil_bvalid  (s_axil_bvalid),
    .s_axil_bready  (s_axil_bready),
    .s_axil_araddr  (s_axil_araddr),
    .s_axil_arvalid (s_axil_arvalid),
    .s_axil_arready (s_axil_arready),
    .s_axil_rdata   (s_axil_rdata),
    .s_axil_rresp   (s_axil_rresp),
    .s_axil_rvalid  (s_axil_rvalid),
    .s_axil_rready  (s_axil_rready),
    .data_i         (data_i),
    .addr_write_o   (addr_write_o),
    .data_o         (data_o),
    .write_en_o     (write_en_o),
    .addr_read_o    (addr_read_o),
    .read_en_o      (read_en_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // native register bank: read data appears the cycle after read_en_o
  always @(posedge clk) begin
    if (write_en_o) mem[addr_write_o[7:0]] <= data_o;
    if (read_en_o)  data_i <= mem[addr_read_o[7:0]];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // scoreboard monitor: pops expectations as the DUT produces strobes and responses
  always @(negedge clk) begin
    if (!arst) begin
      if (write_en_o) begin
        wr_en_cyc = cyc;
        if (wr_q.size() == 0) checkOutput("wr_strobe_unexpected", 32'(write_en_o), 32'd0);
        else begin
          mon_w = wr_q.pop_front();
          checkOutput("wr_addr", 32'(addr_write_o), 32'(mon_w.addr));
          checkOutput("wr_data", data_o, mon_w.data);
        end
      end
      if (read_en_o) begin
        rd_en_cyc = cyc;
        if (rd_addr_q.size() == 0) checkOutput("rd_strobe_unexpected", 32'(read_en_o), 32'd0);
        else begin
          mon_a = rd_addr_q.pop_front();
          checkOutput("rd_addr", 32'(addr_read_o), 32'(mon_a));
        end
      end
      if (s_axil_bvalid && s_axil_bready) begin
        if (b_q.size() == 0) checkOutput("b_unexpected", 32'(s_axil_bvalid), 32'd0);
        else begin
          mon_b = b_q.pop_front();
          checkOutput("bresp", 32'(s_axil_bresp), 32'(mon_b));
        end
      end
      if (s_axil_rvalid && s_axil_rready) begin
        if (r_q.size() == 0) checkOutput("r_unexpected", 32'(s_axil_rvalid), 32'd0);
        else begin
          mon_r = r_q.pop_front();
          checkOutput("rdata", s_axil_rdata, mon_r.data);
          checkOutput("rresp", 32'(s_axil_rresp), 32'(mon_r.resp));
        end
      end
    end
    if (s_axil_bvalid && !bvalid_prev) b_rise_cyc = cyc;
    if (s_axil_rvalid && !rvalid_prev) r_rise_cyc = cyc;
    bvalid_prev = s_axil_bvalid;
    rvalid_prev = s_axil_rvalid;
  end

  task automatic applyStimulus();
    s_axil_awaddr = '0; s_axil_awvalid = 1'b0;
    s_axil_wdata = '0; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b0;
    s_axil_bready = 1'b0;
    s_axil_araddr = '0; s_axil_arvalid = 1'b0;
    s_axil_rready = 1'b0;
  endtask

  task automatic send_aw(input logic [31:0] addr, input int dly);
    repeat (dly) begin @(posedge clk); #1; end
    s_axil_awaddr = addr; s_axil_awvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (s_axil_awready) break; end
    checkOutput("aw_accept", 32'(s_axil_awready), 32'd1);
    @(posedge clk); #1;
    aw_cyc = cyc; s_axil_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input int dly);
    repeat (dly) begin @(posedge clk); #1; end
    s_axil_wdata = data; s_axil_wvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (s_axil_wready) break; end
    checkOutput("w_accept", 32'(s_axil_wready), 32'd1);
    @(posedge clk); #1;
    w_cyc = cyc; s_axil_wvalid = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input int aw_dly,
                           input int w_dly, input int hold, input logic [1:0] resp, input logic strobe);
    wr_exp_t e;
    e.addr = addr[31:2]; e.data = data;
    if (strobe) wr_q.push_back(e);
    b_q.push_back(resp);
    fork
      send_aw(addr, aw_dly);
      send_w(data, w_dly);
    join
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (s_axil_bvalid) break; end
    checkOutput("b_valid", 32'(s_axil_bvalid), 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("b_hold_valid", 32'(s_axil_bvalid), 32'd1);
      checkOutput("b_hold_resp", 32'(s_axil_bresp), 32'(resp));
    end
    @(posedge clk); #1 s_axil_bready = 1'b1;
    @(posedge clk); #1 s_axil_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp,
                          input logic strobe, input int hold);
    rd_exp_t e;
    e.data = data; e.resp = resp;
    if (strobe) rd_addr_q.push_back(addr[31:2]);
    r_q.push_back(e);
    s_axil_araddr = addr; s_axil_arvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (s_axil_arready) break; end
    checkOutput("ar_accept", 32'(s_axil_arready), 32'd1);
    @(posedge clk); #1;
    ar_cyc = cyc; s_axil_arvalid = 1'b0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (s_axil_rvalid) break; end
    checkOutput("r_valid", 32'(s_axil_rvalid), 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("r_hold_valid", 32'(s_axil_rvalid), 32'd1);
      checkOutput("r_hold_data", s_axil_rdata, data);
    end
    @(posedge clk); #1 s_axil_rready = 1'b1;
    @(posedge clk); #1 s_axil_rready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    applyStimulus();
    arst = 1'b1;
    #95;
    checkOutput("rst_ctrl", {25'd0, s_axil_awready, s_axil_wready, s_axil_arready,
                s_axil_bvalid, s_axil_rvalid, write_en_o, read_en_o}, 32'd0);
    checkOutput("rst_addr_write", 32'(addr_write_o), 32'd0);
    checkOutput("rst_addr_read", 32'(addr_read_o), 32'd0);
    checkOutput("rst_data_o", data_o, 32'd0);
    checkOutput("rst_rdata", s_axil_rdata, 32'd0);
    checkOutput("rst_resp", {28'd0, s_axil_bresp, s_axil_rresp}, 32'd0);
    #5 arst = 1'b0;
    #1 checkOutput("ready_before_edge", {29'd0, s_axil_awready, s_axil_wready, s_axil_arready}, 32'd0);
    @(posedge clk); #1;
    checkOutput("ready_first_edge", {29'd0, s_axil_awready, s_axil_wready, s_axil_arready}, 32'd7);

    $display("[TB] aligned write, AW and W together");
    axi_write(32'h10, 32'hDEADBEEF, 0, 0, 0, 2'b00, 1'b1);
    checkOutput("wr_en_latency", 32'(wr_en_cyc), 32'(aw_cyc));
    checkOutput("bvalid_latency", 32'(b_rise_cyc), 32'(aw_cyc + 1));

    $display("[TB] W two cycles before AW, then reads");
    axi_write(32'h14, 32'hCAFEF00D, 2, 0, 0, 2'b00, 1'b1);
    checkOutput("wr_en_after_late_aw", 32'(wr_en_cyc), 32'(aw_cyc));
    axi_read(32'h10, 32'hDEADBEEF, 2'b00, 1'b1, 0);
    checkOutput("rd_en_latency", 32'(rd_en_cyc), 32'(ar_cyc));
    checkOutput("rvalid_latency", 32'(r_rise_cyc), 32'(ar_cyc + 2));
    axi_read(32'h14, 32'hCAFEF00D, 2'b00, 1'b1, 0);

    $display("[TB] random aligned writes and read-back");
    for (int i = 0; i < 10; i++) begin
      rnd_addr[i] = 32'((16 + i * 8 + int'($urandom_range(0, 7))) * 4);
      rnd_data[i] = $urandom;
      axi_write(rnd_addr[i], rnd_data[i], int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                (i % 2) * 5, 2'b00, 1'b1);
    end
    for (int i = 0; i < 10; i++) axi_read(rnd_addr[i], rnd_data[i], 2'b00, 1'b1, ((i + 1) % 2) * 5);

    $display("[TB] simultaneous write and read");
    fork
      axi_write(32'h20, 32'h12345678, 0, 0, 2, 2'b00, 1'b1);
      axi_read(32'h10, 32'hDEADBEEF, 2'b00, 1'b1, 1);
    join
    checkOutput("parallel_strobes", 32'(wr_en_cyc), 32'(rd_en_cyc));
    axi_read(32'h20, 32'h12345678, 2'b00, 1'b1, 0);

    $display("[TB] reset during W_EXEC");
    s_axil_awaddr = 32'h30; s_axil_wdata = 32'h0BADF00D;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    arst = 1'b1;
    #1 checkOutput("rst_wexec", {29'd0, write_en_o, s_axil_bvalid, s_axil_awready}, 32'd0);
    @(negedge clk) arst = 1'b0;
    s_axil_bready = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("rst_wexec_idle", {30'd0, s_axil_bvalid, s_axil_awready}, 32'd1);
    s_axil_bready = 1'b0;

    $display("[TB] reset during R_RESP");
    rd_addr_q.push_back(30'h4);
    s_axil_araddr = 32'h10; s_axil_arvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (s_axil_arready) break; end
    @(posedge clk); #1 s_axil_arvalid = 1'b0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (s_axil_rvalid) break; end
    checkOutput("rresp_reached", 32'(s_axil_rvalid), 32'd1);
    #1 arst = 1'b1;
    #1 checkOutput("rst_rresp", {29'd0, s_axil_rvalid, read_en_o, s_axil_arready}, 32'd0);
    @(negedge clk) arst = 1'b0;
    s_axil_rready = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("rst_rresp_idle", {30'd0, s_axil_rvalid, s_axil_arready}, 32'd1);
    s_axil_rready = 1'b0;
    @(posedge clk); #1;
    axi_read(32'h10, 32'hDEADBEEF, 2'b00, 1'b1, 0);

`ifdef VGA_AXIL_SLVERR_EN
    $display("[TB] misaligned accesses answer SLVERR");
    axi_write(32'h11, 32'hA5A5A5A5, 0, 0, 1, 2'b10, 1'b0);
    checkOutput("slverr_b_latency", 32'(b_rise_cyc), 32'(aw_cyc + 1));
    axi_read(32'h13, 32'h0, 2'b10, 1'b0, 1);
    checkOutput("slverr_r_latency", 32'(r_rise_cyc), 32'(ar_cyc + 2));
    axi_read(32'h10, 32'hDEADBEEF, 2'b00, 1'b1, 0);
`else
    $display("[TB] misaligned accesses ignore low address bits");
    axi_write(32'h19, 32'hA5A5A5A5, 0, 0, 1, 2'b00, 1'b1);
    axi_read(32'h1B, 32'hA5A5A5A5, 2'b00, 1'b1, 1);
`endif

    repeat (3) @(negedge clk);
    checkOutput("wr_q_drained", 32'(wr_q.size()), 32'd0);
    checkOutput("rd_q_drained", 32'(rd_addr_q.size()), 32'd0);
    checkOutput("b_q_drained", 32'(b_q.size()), 32'd0);
    checkOutput("r_q_drained", 32'(r_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/axil_slave_fsm.md
# axil_slave_fsm

AXI4-Lite slave protocol engine for the VGA register space. It accepts AXI-Lite write and read transactions and converts each into a single-cycle native register-bank access: a write strobe with address and data, or a read strobe with address. For reads, it returns the native read data one cycle later as RDATA. It sits between the bus interconnect and the VGA control/status register file.

## Interface
- AXIL_ADDR_W, 32: AXI byte-address width.
- AXIL_DATA_W, 32: data width; fixed at 32.
- NATIVE_ADDR_W, AXIL_ADDR_W-2: word-address width on the native side.
- clk_i  in  1  system clock; all logic on the rising edge.
- arst_i  in  1  asynchronous, active-high reset.
- s_axil_awaddr/awvalid/awready  in/in/out  AXIL_ADDR_W/1/1  write address channel.
- s_axil_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel; wstrb ignored, full-word writes only.
- s_axil_bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
- s_axil_araddr/arvalid/arready  in/in/out  AXIL_ADDR_W/1/1  read address channel.
- s_axil_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel.
- data_i  in  32  native read data; valid the cycle after read_en_o.
- addr_write_o  out  NATIVE_ADDR_W  native write word address = awaddr[AXIL_ADDR_W-1:2].
- data_o  out  32  native write data.
- write_en_o  out  1  single-cycle native write strobe.
- addr_read_o  out  NATIVE_ADDR_W  native read word address = araddr[AXIL_ADDR_W-1:2].
- read_en_o  out  1  single-cycle native read strobe.

## Operation
- The write and read paths are independent FSMs. Simultaneous read and write transactions proceed in parallel.
- Write FSM states: W_IDLE, W_EXEC, W_RESP.
  - In W_IDLE, AW and W are accepted independently and in any order. Each ready drops after its handshake.
  - When both AW and W are held, the FSM moves to W_EXEC.
  - W_EXEC drives write_en_o=1 for exactly one cycle, with addr_write_o and data_o stable. It then moves to W_RESP.
  - W_RESP holds bvalid=1 with bresp until bready. On the handshake, the FSM returns to W_IDLE.
- Read FSM states: R_IDLE, R_EXEC, R_CAPT, R_RESP.
  - In R_IDLE, arready=1; an AR handshake moves the FSM to R_EXEC.
  - R_EXEC drives read_en_o=1 for one cycle with addr_read_o.
  - R_CAPT registers data_i into rdata.
  - R_RESP holds rvalid=1 and rdata/rresp stable until rready. On the handshake, the FSM returns to R_IDLE.
- Responses are OKAY (2'b00), except as defined under Configuration.
- addr_write_o, addr_read_o and data_o are registers and hold their last value between transactions.
- Reset values: every output is 0, including all readies, valids, strobes, addresses, data and resp.

## Timing
- Readies assert on the first clock edge after arst_i deasserts.
- Write, AW and W in the same cycle at edge N: write_en_o is high in cycle N+1 and bvalid is high from cycle N+2. With bready already high, the next AW/W is accepted no earlier than N+3.
- Read, AR handshake at edge N:
  - read_en_o is high in cycle N+1.
  - data_i is sampled at the end of cycle N+2.
  - rvalid is high from cycle N+3.
- awready/wready are low during W_EXEC and W_RESP; arready is low outside R_IDLE.
- bvalid/rvalid never drop without a handshake. Payloads are stable while valid is high.
- Reset mid-transaction is asynchronous: both FSMs return to idle immediately and all valids and strobes drop. The pending transaction is discarded, with no native strobe and no response.

## Configuration
- VGA_AXIL_SLVERR_EN defined:
  - A write with awaddr[1:0]≠0 returns bresp=SLVERR (2'b10) and produces no write_en_o.
  - A read with araddr[1:0]≠0 returns rresp=SLVERR and rdata=0, with no read_en_o.
  - Handshake timing is unchanged; the strobe cycle is still spent idle.
- VGA_AXIL_SLVERR_EN undefined: the low address bits are ignored and every response is OKAY.

## Structure
- Package vga_axil_pkg holds:
  - axil_addr_t, axil_data_t and native_addr_t;
  - axil_resp_e: OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3;
  - the width constants.
- The read path is a natural sub-module, axil_slave_rd_fsm. The write FSM stays in the top level.

## Test plan
- Reset: hold arst_i for 100 ns -> all outputs 0; readies rise on the first edge after release.
- Write awaddr=0x10 and wdata=0xDEADBEEF with AW and W in the same cycle -> write_en_o pulses once with addr_write_o=0x4 and data_o=0xDEADBEEF, then bresp=OKAY.
- Write with W two cycles before AW, then read 0x10 with the model returning the stored word -> read_en_o pulses with addr_read_o=0x4; rdata=0xDEADBEEF, rresp=OKAY at N+3.
- 10 random aligned writes followed by reads of the same addresses -> all data matches and all responses are OKAY; bready/rready held low for 5 cycles keep valid and payload stable.
- Simultaneous AW/W/AR in one cycle -> both strobes fire and both responses complete independently.
- Reset asserted in W_EXEC and in R_RESP -> valids drop at once with no extra strobe. With VGA_AXIL_SLVERR_EN, awaddr=0x11 -> bresp=SLVERR and no write_en_o.
